// File: rtl/reorder_buffer.sv
// Purpose : in-order retirement buffer; allocates on dispatch, marks done on writeback,
//           retires in program order and requests register-file snapshot restore on mispredict.
// Latency : completion at edge c -> retire pulse in cycle c+2 (c+1 with ROB_RETIRE_BYPASS_EN);
//           mispredict at edge c -> restore pulse in cycle c+1.
// Backpressure: dispatch_ready (combinational) drops when full, when a branch finds no free
//           checkpoint, during a mispredict cycle and during reset.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   dispatch_valid/ready            allocation handshake; dispatch_tag is the tag granted (tail)
//   dispatch_uses_rw/rw/is_branch   per-instruction attributes stored in the entry
//   complete_valid/tag/mispredict   writeback completion
//   retire_valid, retired_uses_rw,
//   retired_rw                      registered one-cycle retire pulse to the recycle port
//   restore, restore_entry          registered one-cycle snapshot-restore request
//   occupancy                       registered live-entry count
//
// Optional feature macro: ROB_RETIRE_BYPASS_EN (a non-mispredict completion of the head
// entry retires in the cycle it is sampled). Undefined by default.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int CKPT_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic             dispatch_uses_rw,
  input  logic [5:0]       dispatch_rw,
  input  logic             dispatch_is_branch,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  input  logic             complete_mispredict,
  output logic             retired_uses_rw,
  output logic [5:0]       retired_rw,
  output logic             retire_valid,
  output logic             restore,
  output logic [1:0]       restore_entry,
  output logic [TAG_W:0]   occupancy
);

  typedef struct packed {
    logic       live;
    logic       done;
    logic       uses_rw;
    logic [5:0] rw;
    logic       is_branch;
    logic [1:0] ckpt_id;
  } rob_entry_t;

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);
  // Checkpoint ring is 2 bits wide to match the register file's four snapshots.
  localparam logic [2:0]     CKPT_FULL = 3'(CKPT_N);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [1:0]       ckpt_head_q, ckpt_head_d, ckpt_tail_q, ckpt_tail_d;
  logic [2:0]       ckpt_cnt_q, ckpt_cnt_d;
  logic             retire_valid_q, retire_valid_d;
  logic             retired_uses_rw_q, retired_uses_rw_d;
  logic [5:0]       retired_rw_q, retired_rw_d;
  logic             restore_q, restore_d;
  logic [1:0]       restore_entry_q, restore_entry_d;

  rob_entry_t       head_ent, cpl_ent;
  logic             cpl_live, mispredict, head_done, retire_fire, retire_br;
  logic             dispatch_fire, dispatch_br;
  logic [TAG_W-1:0] t_off;
  logic [1:0]       k_off;

  always_comb begin
    head_ent   = ent_q[head_q];
    cpl_ent    = ent_q[complete_tag];
    cpl_live   = complete_valid && cpl_ent.live;
    // A mispredict flag only matters on a live branch; otherwise it is a plain completion.
    mispredict = cpl_live && complete_mispredict && cpl_ent.is_branch;

`ifdef ROB_RETIRE_BYPASS_EN
    head_done = head_ent.done ||
                (complete_valid && (complete_tag == head_q) &&
                 !(complete_mispredict && head_ent.is_branch));
`else
    head_done = head_ent.done;
`endif
    retire_fire = head_ent.live && head_done;
    retire_br   = retire_fire && head_ent.is_branch;

    dispatch_ready = !reset && (count_q < DEPTH_CNT) &&
                     !(dispatch_is_branch && (ckpt_cnt_q == CKPT_FULL)) &&
                     !(complete_valid && complete_mispredict);
    dispatch_fire  = dispatch_valid && dispatch_ready;
    dispatch_br    = dispatch_fire && dispatch_is_branch;
    dispatch_tag   = tail_q;
    occupancy      = count_q;

    // Age of the mispredicting entry relative to head, and of its checkpoint relative
    // to the oldest checkpoint; both wrap naturally in their pointer widths.
    t_off = complete_tag - head_q;
    k_off = cpl_ent.ckpt_id - ckpt_head_q;

    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + (TAG_W+1)'(dispatch_fire) - (TAG_W+1)'(retire_fire);
    ckpt_head_d = ckpt_head_q + 2'(retire_br);
    ckpt_tail_d = ckpt_tail_q;
    ckpt_cnt_d  = ckpt_cnt_q + 3'(dispatch_br) - 3'(retire_br);

    if (cpl_live) begin
      ent_d[complete_tag].done = 1'b1;
    end

    if (retire_fire) begin
      ent_d[head_q].live = 1'b0;
      ent_d[head_q].done = 1'b0;
      head_d             = head_q + 1'b1;
    end

    // Dispatch never coincides with a mispredict, and tail never aliases a retiring head
    // (tail==head only when empty or full), so these writes cannot collide.
    if (dispatch_fire) begin
      ent_d[tail_q].live      = 1'b1;
      ent_d[tail_q].done      = 1'b0;
      ent_d[tail_q].uses_rw   = dispatch_uses_rw;
      ent_d[tail_q].rw        = dispatch_rw;
      ent_d[tail_q].is_branch = dispatch_is_branch;
      ent_d[tail_q].ckpt_id   = dispatch_is_branch ? ckpt_tail_q : 2'd0;
      tail_d                  = tail_q + 1'b1;
      if (dispatch_is_branch) begin
        ckpt_tail_d = ckpt_tail_q + 1'b1;
      end
    end

    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (TAG_W'(TAG_W'(i) - head_q) > t_off) begin
          ent_d[i].live = 1'b0;
          ent_d[i].done = 1'b0;
        end
      end
      tail_d      = complete_tag + 1'b1;
      count_d     = {1'b0, t_off} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_fire);
      ckpt_tail_d = cpl_ent.ckpt_id + 1'b1;
      ckpt_cnt_d  = {1'b0, k_off} + 3'd1 - 3'(retire_br);
    end

    retire_valid_d    = retire_fire;
    retired_uses_rw_d = retire_fire && head_ent.uses_rw;
    retired_rw_d      = retire_fire ? head_ent.rw : 6'd0;
    restore_d         = mispredict;
    restore_entry_d   = mispredict ? cpl_ent.ckpt_id : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      ckpt_head_q       <= '0;
      ckpt_tail_q       <= '0;
      ckpt_cnt_q        <= '0;
      retire_valid_q    <= 1'b0;
      retired_uses_rw_q <= 1'b0;
      retired_rw_q      <= '0;
      restore_q         <= 1'b0;
      restore_entry_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      ckpt_head_q       <= ckpt_head_d;
      ckpt_tail_q       <= ckpt_tail_d;
      ckpt_cnt_q        <= ckpt_cnt_d;
      retire_valid_q    <= retire_valid_d;
      retired_uses_rw_q <= retired_uses_rw_d;
      retired_rw_q      <= retired_rw_d;
      restore_q         <= restore_d;
      restore_entry_q   <= restore_entry_d;
    end
  end

  assign retire_valid    = retire_valid_q;
  assign retired_uses_rw = retired_uses_rw_q;
  assign retired_rw      = retired_rw_q;
  assign restore         = restore_q;
  assign restore_entry   = restore_entry_q;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order MIPS core, sitting between decode/dispatch and the renaming register file. It allocates one entry per dispatched instruction, marks entries complete from writeback, and retires them strictly in program order. Each retirement drives the register file's physical-register recycle port (`retired_uses_rw`, `retired_rw`). On a branch mispredict it drives the register file's snapshot-restore request (`reset`, `entry`) and squashes every younger entry.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two.
- `TAG_W`, 4: entry tag width, log2(`DEPTH`).
- `CKPT_N`, 4: number of branch checkpoints; matches the register file's 4 snapshots.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `dispatch_valid` in 1: dispatch request.
- `dispatch_ready` out 1: entry available; combinational.
- `dispatch_uses_rw` in 1: the instruction writes a register.
- `dispatch_rw` in 6: destination register address, passed through to retirement.
- `dispatch_is_branch` in 1: conditional branch; consumes a checkpoint.
- `dispatch_tag` out `TAG_W`: tag assigned to this dispatch; equals tail.
- `complete_valid` in 1: writeback completion.
- `complete_tag` in `TAG_W`: tag of the completing entry.
- `complete_mispredict` in 1: the completing branch was mispredicted.
- `retired_uses_rw` out 1: one-cycle retire pulse; high only if the retired entry writes a register.
- `retired_rw` out 6: destination of the retired entry.
- `retire_valid` out 1: one-cycle pulse per retired entry.
- `restore` out 1: one-cycle snapshot-restore request; drives the register file's `reset`.
- `restore_entry` out 2: checkpoint id to restore; drives the register file's `entry`.
- `occupancy` out `TAG_W+1`: number of live entries.

## Operation
- **Storage.** Circular array with `head`, `tail` and `count`. Each entry holds {live, done, uses_rw, rw, is_branch, ckpt_id}.
- **Checkpoint pointers.** `ckpt_tail` and `ckpt_head` are 2-bit wrapping pointers. `ckpt_cnt` is 0..`CKPT_N`.
- **Dispatch ready.** `dispatch_ready` = !reset && count<`DEPTH` && !(dispatch_is_branch && ckpt_cnt==`CKPT_N`) && !(complete_valid && complete_mispredict).
- **Dispatch.** Fires on valid&&ready. Writes an entry at tail with done=0, then tail+1 and count+1.
  - If it is a branch: ckpt_id=ckpt_tail, then ckpt_tail+1 and ckpt_cnt+1.
- **Completion.** Sets done on a live entry. Completion to a dead tag is ignored. A mispredict flag on a non-branch entry is treated as a plain completion.
- **Retire.** Fires when the head entry is live and done; at most one per cycle. Clears live and advances head.
  - If the retired entry is a branch: ckpt_head+1 and ckpt_cnt-1.
- **Mispredict on a live branch at tag T with ckpt_id K:**
  - Kill all entries younger than T; tail <= T+1.
  - count <= ((T-head) mod `DEPTH`)+1, minus 1 if head retires the same cycle.
  - ckpt_tail <= K+1; ckpt_cnt <= ((K-ckpt_head) mod 4)+1, adjusted for a same-cycle branch retire.
  - Next cycle: `restore`=1, `restore_entry`=K.
- **Simultaneous events.**
  - Retire of head and mispredict in the same cycle: both take effect, since head is older.
  - Dispatch in a mispredict cycle is blocked by `dispatch_ready`.
  - Dispatch, complete and retire in the same cycle: all take effect; count changes by the net amount.
- **Wrap-around.** All pointer arithmetic is modulo `DEPTH` (tags) or 4 (checkpoints). Full versus empty is distinguished by count only.

## Timing
- **Reset values.** head=tail=count=0, all entries dead, ckpt pointers and ckpt_cnt 0. All outputs 0 except `dispatch_ready`=1 (the cycle after reset deasserts) and `dispatch_tag`=0.
- **Reset mid-operation.** Discards all entries; no restore or retire pulse is issued.
- **Retire latency.** Completion sampled at edge c makes done visible in cycle c+1. Retire outputs are registered, so `retire_valid` and `retired_*` are high during cycle c+2, one cycle wide.
- **Retire throughput.** One retire per cycle sustained.
- **Restore latency.** Mispredict sampled at edge c puts `restore` high in cycle c+1 for exactly one cycle.
- **Occupancy.** `occupancy` reflects the register state of count.

## Configuration
- `ROB_RETIRE_BYPASS_EN` defined: a completion whose tag equals head (non-mispredict) retires in the same cycle as it is sampled. Retire outputs then pulse in cycle c+1.
- `ROB_RETIRE_BYPASS_EN` undefined: retirement only from registered done state, as in Timing (cycle c+2). This is the default.

## Test plan
- **Basic retire.** Reset, dispatch 3 non-branch entries (rw=5,6,7, uses_rw=1), complete tags 2,1,0 in that order. Expect retire pulses in order rw=5,6,7, the first 2 cycles after tag 0 completes; then `occupancy`=0.
- **Full.** Dispatch 16 entries. Expect `dispatch_ready`=0 and `occupancy`=16. Complete and retire tag 0, then dispatch once: expect `dispatch_tag`=0 (wrap).
- **Checkpoint limit.** Dispatch 4 branches. Expect `dispatch_ready`=0 while `dispatch_is_branch`=1, but =1 for a non-branch.
- **Mispredict.** Dispatch A, B(branch, ckpt 0), C, D; complete B with mispredict. Expect:
  - next cycle `restore`=1, `restore_entry`=0;
  - `occupancy`=2 and next `dispatch_tag`=2;
  - C and D never retire.
- **Out-of-order completion.** Retire with uses_rw=0 entry: expect `retire_valid`=1, `retired_uses_rw`=0.
- **Reset mid-operation.** Assert `reset` with 5 live entries and a pending mispredict. Expect no `restore` pulse and all counters 0 next cycle.
